systolic_ctrl: RTL

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
//
// Operand sequencer for an N x N output-stationary systolic array. Holds the
// A and B operand matrices in local buffers and, on start, clears the PE
// accumulators, streams skewed A rows into the left edge and skewed B columns
// into the top edge, waits DRAIN zero-feed cycles for the last partial sums
// to settle, then pulses done.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous reset, active low
//   ld_en    in   buffer write strobe (ignored while busy)
//   ld_sel   in   write target: 0 = A buffer, 1 = B buffer
//   ld_row   in   element row index
//   ld_col   in   element column index
//   ld_data  in   element value
//   start    in   request one pass (honoured only in IDLE)
//   clear    out  accumulator clear to all PEs
//   a_row    out  left-edge feeds, row i in [i*DATA_W +: DATA_W]
//   b_col    out  top-edge feeds, column j in [j*DATA_W +: DATA_W]
//   busy     out  pass in progress
//   done     out  single-cycle completion pulse
//
// State   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start, buffers writable
// S_CLEAR | one cycle, accumulators cleared
// S_FEED  | 3N-2 cycles, cnt counts up as feed time t
// S_DRAIN | DRAIN cycles of zero feed, cnt counts down to 0
// S_DONE  | one cycle done pulse, buffers writable
// ---------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int DRAIN  = 2 * N,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_en,
    input  logic                  ld_sel,
    input  logic [IDX_W-1:0]      ld_row,
    input  logic [IDX_W-1:0]      ld_col,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  start,
    output logic                  clear,
    output logic [N*DATA_W-1:0]   a_row,
    output logic [N*DATA_W-1:0]   b_col,
    output logic                  busy,
    output logic                  done
);

    localparam int FEED_CYC = 3 * N - 2;
    localparam int CNT_MAX  = (FEED_CYC > DRAIN) ? FEED_CYC : DRAIN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN > 0) ? DRAIN - 1 : 0);
    localparam logic [IDX_W:0]   N_LIM      = (IDX_W + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_buf_q [N][N];
    logic [DATA_W-1:0]  a_buf_d [N][N];
    logic [DATA_W-1:0]  b_buf_q [N][N];
    logic [DATA_W-1:0]  b_buf_d [N][N];

    logic               wr_ok;
    logic [31:0]        t_ext;

    // ------------------------------------------------------------------
    // Buffer write path. busy is a pure function of state_q, so a write
    // presented together with start in IDLE still lands before the pass
    // reaches FEED.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ok = ld_en && !busy
                && ({1'b0, ld_row} < N_LIM)
                && ({1'b0, ld_col} < N_LIM);
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        if (wr_ok) begin
            if (ld_sel) begin
                b_buf_d[ld_row][ld_col] = ld_data;
            end else begin
                a_buf_d[ld_row][ld_col] = ld_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                clear   = 1'b1;
                busy    = 1'b1;
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                busy = 1'b1;
                if (cnt_q == FEED_LAST) begin
                    // A zero-length drain goes straight to the done pulse.
                    if (DRAIN > 0) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skewed edge feeds. In feed time t, row i carries A[i][k] and column
    // j carries B[k][j] where k = t - i (resp. t - j); every other slot
    // is zero, which also gives the ramp-in/ramp-out padding.
    // ------------------------------------------------------------------
    assign t_ext = 32'(cnt_q);

    always_comb begin
        a_row = '0;
        b_col = '0;
        if (state_q == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (t_ext == 32'(i + k)) begin
                        a_row[i*DATA_W +: DATA_W] = a_buf_q[i][k];
                        b_col[i*DATA_W +: DATA_W] = b_buf_q[k][i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf_q[i][j] <= '0;
                    b_buf_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
        end
    end

endmodule
